// File: rtl/kan_pkg.sv
// Shared constants and helpers for the KAN activation datapath.
// Lane 0 occupies the most significant 16 bits of a packed word.
package kan_pkg;

  localparam int unsigned KAN_LANE_WIDTH = 16;
  localparam int unsigned KAN_LANES      = 4;

  typedef logic [KAN_LANE_WIDTH-1:0]           kan_lane_t;
  typedef logic [KAN_LANES*KAN_LANE_WIDTH-1:0] kan_word_t;

  function automatic kan_lane_t lane_sel(input kan_word_t word, input logic [1:0] idx);
    return word[63 - 16*idx -: 16];
  endfunction

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/kan_word_buf.sv
// Two-entry synchronous FIFO with the head held directly in a register.
// Push and pop on the same edge keep occupancy unchanged.
module kan_word_buf #(
  parameter int W = 64
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_push, do_pop;

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign head_o  = head_q;

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case ({do_push, do_pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = data_i;
        else               tail_d = data_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        // Occupancy stays put; the new word lands behind whatever remains.
        if (cnt_q == 2'd1) begin
          head_d = data_i;
        end else begin
          head_d = tail_q;
          tail_d = data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/kan_act_serializer.sv
// Unpacks 4-lane layer-output words into a per-element stream with tlast at the layer end.
// Optional length checker (len_err port) is built when KAN_SER_LENCHK_EN is defined.
module kan_act_serializer
  import kan_pkg::*;
#(
  parameter int LG_LAYERSIZE = 12,
  parameter int IN_DATAWIDTH = 64,
  parameter int LANE_WIDTH   = 16,
  parameter int LANES        = 4
) (
  input  logic                    s_axis_aclk,
  input  logic                    s_axis_aresetn,
  input  logic [IN_DATAWIDTH-1:0] s_axis_tdata,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  output logic [LANE_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  input  logic [LG_LAYERSIZE-1:0] layer_size
`ifdef KAN_SER_LENCHK_EN
  ,
  output logic                    len_err
`endif
);

  localparam int LGW = LG_LAYERSIZE + 1;
  localparam int BW  = LG_LAYERSIZE + IN_DATAWIDTH;

  logic                    rdy_q;
  logic                    buf_push, buf_pop, buf_full, buf_empty;
  logic [BW-1:0]           buf_head;
  logic [LG_LAYERSIZE-1:0] head_size;
  logic [IN_DATAWIDTH-1:0] head_word;

  logic                    in_busy_q, in_busy_d;
  logic [LG_LAYERSIZE-1:0] in_size_q, in_size_d;
  logic [LGW-1:0]          in_wcnt_q, in_wcnt_d;
  logic [LG_LAYERSIZE-1:0] in_size_eff;
  logic [LGW-1:0]          in_size_ext, in_words_m1;
  logic                    in_last_word, s_acc;

  logic [1:0]              lane_q, lane_d;
  logic [LG_LAYERSIZE-1:0] elem_q, elem_d;
  logic                    m_hs;

  // tready stays low while in reset and for the first edge after release.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) rdy_q <= 1'b0;
    else                 rdy_q <= 1'b1;
  end

  assign s_axis_tready = rdy_q & ~buf_full;
  assign s_acc         = s_axis_tvalid & s_axis_tready;

  // Input side tracks layer boundaries so each buffered word carries its own layer size;
  // this lets the next layer's first word be queued while the previous tail drains.
  assign in_size_eff  = in_busy_q ? in_size_q : layer_size;
  assign in_size_ext  = (in_size_eff == '0) ? {1'b1, {LG_LAYERSIZE{1'b0}}} : {1'b0, in_size_eff};
  assign in_words_m1  = LGW'(ceil_div(32'(in_size_ext), 32'(LANES))) - LGW'(1);
  assign in_last_word = (in_wcnt_q == in_words_m1);

  always_comb begin
    in_busy_d = in_busy_q;
    in_size_d = in_size_q;
    in_wcnt_d = in_wcnt_q;
    if (s_acc) begin
      if (!in_busy_q) in_size_d = layer_size;
      if (in_last_word) begin
        in_busy_d = 1'b0;
        in_wcnt_d = '0;
      end else begin
        in_busy_d = 1'b1;
        in_wcnt_d = in_wcnt_q + LGW'(1);
      end
    end
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      in_busy_q <= 1'b0;
      in_size_q <= '0;
      in_wcnt_q <= '0;
    end else begin
      in_busy_q <= in_busy_d;
      in_size_q <= in_size_d;
      in_wcnt_q <= in_wcnt_d;
    end
  end

  assign buf_push = s_acc;

  kan_word_buf #(
    .W (BW)
  ) u_buf (
    .clk_i   (s_axis_aclk),
    .rst_ni  (s_axis_aresetn),
    .push_i  (buf_push),
    .data_i  ({in_size_eff, s_axis_tdata}),
    .pop_i   (buf_pop),
    .head_o  (buf_head),
    .full_o  (buf_full),
    .empty_o (buf_empty)
  );

  assign {head_size, head_word} = buf_head;

  // Size 0 wraps to 2^LG_LAYERSIZE-1 here, which is the last index of a full-size layer.
  assign m_axis_tvalid = ~buf_empty;
  assign m_axis_tdata  = lane_sel(head_word, lane_q);
  assign m_axis_tlast  = m_axis_tvalid & (elem_q == head_size - LG_LAYERSIZE'(1));
  assign m_hs          = m_axis_tvalid & m_axis_tready;
  assign buf_pop       = m_hs & (m_axis_tlast | (lane_q == 2'(LANES - 1)));

  always_comb begin
    lane_d = lane_q;
    elem_d = elem_q;
    if (m_hs) begin
      if (m_axis_tlast) begin
        lane_d = 2'd0;
        elem_d = '0;
      end else begin
        lane_d = lane_q + 2'd1;
        elem_d = elem_q + LG_LAYERSIZE'(1);
      end
    end
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      lane_q <= 2'd0;
      elem_q <= '0;
    end else begin
      lane_q <= lane_d;
      elem_q <= elem_d;
    end
  end

`ifdef KAN_SER_LENCHK_EN
  logic len_err_q;

  // Flags tlast on a non-final word or a final word without tlast; never affects data flow.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn)                            len_err_q <= 1'b0;
    else if (s_acc && (s_axis_tlast != in_last_word)) len_err_q <= 1'b1;
  end

  assign len_err = len_err_q;
`else
  logic tlast_unused;
  assign tlast_unused = s_axis_tlast;
`endif

endmodule

// File: tb/tb_kan_act_serializer.sv
// Randomised bench for kan_act_serializer with a queue-based element model.
// Builds with or without KAN_SER_LENCHK_EN.
module tb_kan_act_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_tready;
  logic [15:0] m_tdata;
  logic        m_tvalid, m_tlast;
  logic        m_tready = 1'b0;
  logic [11:0] layer_size = '0;
`ifdef KAN_SER_LENCHK_EN
  logic        len_err;
`endif

  always #5 clk = ~clk;

  kan_act_serializer dut (
    .s_axis_aclk    (clk),
    .s_axis_aresetn (rst_n),
    .s_axis_tdata   (s_tdata),
    .s_axis_tvalid  (s_tvalid),
    .s_axis_tlast   (s_tlast),
    .s_axis_tready  (s_tready),
    .m_axis_tdata   (m_tdata),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tlast   (m_tlast),
    .m_axis_tready  (m_tready),
    .layer_size     (layer_size)
`ifdef KAN_SER_LENCHK_EN
    ,
    .len_err        (len_err)
`endif
  );

  typedef struct {
    logic [15:0] data;
    logic        last;
  } elem_t;

  elem_t       exp_q[$];
  int          hs_cyc[$];
  int          hs_cnt = 0;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_bad = 0;
  int          mode = 0;
  int          pat_idx = 0;
  int          acc_cyc = 0;
  int          first_acc = 0;
  int          tot_waits = 0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data = '0;
  logic        prev_last = 1'b0;
  elem_t       mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] seq_word(input int i);
    return {16'(4*i+1), 16'(4*i+2), 16'(4*i+3), 16'(4*i+4)};
  endfunction

  // Model: a layer of sz elements is the first sz lanes of its words, lane 0 first.
  task automatic push_exp(input logic [63:0] w, input int base, input int sz);
    elem_t e;
    for (int l = 0; l < 4; l++) begin
      if (base + l < sz) begin
        e.data = 16'(w >> (48 - 16*l));
        e.last = (base + l == sz - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic send_word(input logic [63:0] w, input logic [11:0] sz, input logic tl,
                           output int waits);
    int n = 0;
    s_tdata = w; layer_size = sz; s_tlast = tl; s_tvalid = 1'b1;
    while (!s_tready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!s_tready) chk("in_timeout", 64'(s_tready), 1);
    acc_cyc = cyc;
    @(posedge clk);
    @(negedge clk);
    s_tvalid = 1'b0;
    waits = n;
  endtask

  task automatic send_layer(input int sz, input int gapmax, input bit seq, input int bad_last);
    int nw = (sz + 3) / 4;
    int waits;
    logic [63:0] w;
    logic [11:0] lsz;
    for (int i = 0; i < nw; i++) begin
      w = seq ? seq_word(i) : {$urandom, $urandom};
      push_exp(w, 4*i, sz);
      lsz = (i == 0) ? 12'(sz) : 12'($urandom);
      if (gapmax > 0 && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, gapmax)) @(negedge clk);
      send_word(w, lsz, (bad_last < 0) ? (i == nw - 1) : (i == bad_last), waits);
      tot_waits += waits;
      if (i == 0) first_acc = acc_cyc;
    end
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      @(negedge clk); #2;
      n++;
    end
    chk(tag, 64'(exp_q.size()), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_s_tready"}, 64'(s_tready), 0);
    chk({tag, "_m_tvalid"}, 64'(m_tvalid), 0);
    chk({tag, "_m_tlast"}, 64'(m_tlast), 0);
    chk({tag, "_m_tdata"}, 64'(m_tdata), 0);
`ifdef KAN_SER_LENCHK_EN
    chk({tag, "_len_err"}, 64'(len_err), 0);
`endif
  endtask

  // Output monitor: drives m_tready per mode, checks AXIS hold and element order.
  initial begin
    forever begin
      @(negedge clk);
      case (mode)
        0: m_tready = 1'b1;
        1: m_tready = ($urandom_range(0, 9) < 7);
        2: begin
          m_tready = (pat_idx % 4 == 0) || (pat_idx % 4 == 3);
          pat_idx++;
        end
        default: m_tready = 1'b0;
      endcase
      #1;
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", 64'(m_tvalid), 1);
          chk("hold_data", 64'(m_tdata), 64'(prev_data));
          chk("hold_last", 64'(m_tlast), 64'(prev_last));
        end
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            chk("extra_elem", 64'(m_tvalid), 0);
          end else begin
            mon_e = exp_q.pop_front();
            chk("data", 64'(m_tdata), 64'(mon_e.data));
            chk("last", 64'(m_tlast), 64'(mon_e.last));
          end
          hs_cnt++;
          hs_cyc.push_back(cyc);
        end
        prev_stall = m_tvalid && !m_tready;
        prev_data  = m_tdata;
        prev_last  = m_tlast;
      end
    end
  end

  initial begin
    int waits;
    int n;
    logic [63:0] w;

    repeat (3) @(negedge clk);
    #1 check_reset_outputs("rst");
    @(negedge clk) rst_n = 1'b1;

    // T1 basic
    @(negedge clk);
    hs_cyc.delete(); tot_waits = 0;
    send_layer(8, 0, 1, -1);
    wait_drain("t1_drain");
    chk("t1_in_stall", 64'(tot_waits), 0);
    chk("t1_latency", 64'(hs_cyc[0]), 64'(first_acc + 1));
    chk("t1_burst", 64'(hs_cyc[7] - hs_cyc[0]), 7);
    chk("t1_count", 64'(hs_cyc.size()), 8);

    // T2 partial word then next layer
    @(negedge clk);
    hs_cyc.delete();
    send_layer(6, 0, 1, -1);
    send_layer(4, 0, 0, -1);
    wait_drain("t2_drain");
    chk("t2_next_gap", 64'(hs_cyc[6] - hs_cyc[5]), 1);
    chk("t2_count", 64'(hs_cyc.size()), 10);

    // T3 backpressure pattern, then full stall refusing a third word
    @(negedge clk);
    mode = 2; pat_idx = 0;
    send_layer(8, 0, 1, -1);
    wait_drain("t3_drain");
    mode = 3;
    @(negedge clk);
    for (int i = 0; i < 3; i++) push_exp(seq_word(i), 4*i, 12);
    send_word(seq_word(0), 12'd12, 1'b0, waits);
    send_word(seq_word(1), 12'($urandom), 1'b0, waits);
    s_tdata = seq_word(2); s_tlast = 1'b1; layer_size = 12'($urandom); s_tvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #2;
      chk("t3_refuse", 64'(s_tready), 0);
    end
    mode = 0;
    send_word(seq_word(2), layer_size, 1'b1, waits);
    wait_drain("t3b_drain");

    // T4 reset after 3 of 8 elements
    @(negedge clk);
    hs_cnt = 0;
    send_layer(8, 0, 1, -1);
    n = 0;
    while (hs_cnt < 3 && n < 100) begin
      @(negedge clk); #2;
      n++;
    end
    chk("t4_reach3", 64'(hs_cnt), 3);
    @(posedge clk); #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1 check_reset_outputs("t4_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    hs_cnt = 0;
    send_layer(8, 0, 1, -1);
    wait_drain("t4_drain");
    chk("t4_count", 64'(hs_cnt), 8);

    // T5 back-to-back layers of 4 and 5
    @(negedge clk);
    hs_cyc.delete();
    send_layer(4, 0, 0, -1);
    send_layer(5, 0, 0, -1);
    wait_drain("t5_drain");
    chk("t5_burst", 64'(hs_cyc[8] - hs_cyc[0]), 8);

    // T6 tlast on the first word of an 8-element layer
`ifdef KAN_SER_LENCHK_EN
    chk("t6_clean", 64'(len_err), 0);
`endif
    @(negedge clk);
    w = seq_word(0);
    push_exp(w, 0, 8);
    send_word(w, 12'd8, 1'b1, waits);
`ifdef KAN_SER_LENCHK_EN
    chk("t6_set", 64'(len_err), 1);
`endif
    w = seq_word(1);
    push_exp(w, 4, 8);
    send_word(w, 12'($urandom), 1'b0, waits);
    wait_drain("t6_drain");
`ifdef KAN_SER_LENCHK_EN
    repeat (3) @(negedge clk);
    chk("t6_sticky", 64'(len_err), 1);
`endif

    // Random layers with gaps and random backpressure, then one full-size layer
    mode = 1;
    for (int k = 0; k < 25; k++) send_layer($urandom_range(1, 40), 3, 0, -1);
    wait_drain("rand_drain");
    send_layer(4096, 0, 0, -1);
    send_layer($urandom_range(1, 9), 0, 0, -1);
    wait_drain("full_drain");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
